hazard_unit: RTL

- Hazard resolution block for the 5-stage ARM pipeline; the consumer of the hazard outputs the pipeline controller exports (PCWrPendingF, MemtoRegE, RegWriteM, RegWriteW, PCSrcW, BranchTakenE).
- Produces forwarding selects, stall and flush controls for the datapath and controller.
- Carries its own Decode-to-Execute copy of source-register addresses, a stall watchdog, and saturating performance counters.

---
 rtl/hazard_unit_pkg.sv | 16 +
 rtl/hazard_unit_if.sv | 41 ++++
 rtl/hazard_counter.sv | 24 ++
 rtl/hazard_unit.sv | 116 +++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared constants and helpers for the ARM pipeline hazard unit.
package hazard_unit_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [3:0] PC_REG = 4'd15;

    // Memory stage holds the younger result, so it wins over Writeback.
    function automatic logic [1:0] fwd_select(input logic match_m, input logic match_w);
        if (match_m)      return FWD_M;
        else if (match_w) return FWD_W;
        else              return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle; master is the pipeline, slave the hazard unit.
interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       RA1D;
    logic [3:0]       RA2D;
    logic [3:0]       WA3E;
    logic [3:0]       WA3M;
    logic [3:0]       WA3W;
    logic             MemtoRegE;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             PCWrPendingF;
    logic             PCSrcW;
    logic             BranchTakenE;

    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic             HazErr;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output RA1D, RA2D, WA3E, WA3M, WA3W,
        output MemtoRegE, RegWriteM, RegWriteW, PCWrPendingF, PCSrcW, BranchTakenE,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        input  HazErr, StallCount, FlushCount
    );

    modport slave (
        input  RA1D, RA2D, WA3E, WA3M, WA3W,
        input  MemtoRegE, RegWriteM, RegWriteW, PCWrPendingF, PCSrcW, BranchTakenE,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        output HazErr, StallCount, FlushCount
    );

endinterface

// File: rtl/hazard_counter.sv
// Saturating, enable-gated event counter with asynchronous active-low clear.
module hazard_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Forwarding, load-use stall and branch flush control for the 5-stage ARM pipeline,
// with a stall watchdog and saturating stall/flush event counters.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 8
) (
    input  logic        clk,
    input  logic        reset,
    hazard_unit_if.slave hu
);

    localparam logic [7:0] STALL_LAST = 8'(MAX_STALL - 1);

    logic [3:0] r_ra1e;
    logic [3:0] r_ra2e;
    logic [7:0] r_stall_run;
    logic       r_haz_err;

    logic       w_ldr_stall;
    logic       w_stall_f;
    logic       w_stall_d;
    logic       w_flush_d;
    logic       w_flush_e;
    logic       w_match_1m;
    logic       w_match_1w;
    logic       w_match_2m;
    logic       w_match_2w;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_ldr_stall = 1'b0;
        w_match_1m  = 1'b0;
        w_match_1w  = 1'b0;
        w_match_2m  = 1'b0;
        w_match_2w  = 1'b0;
        w_fwd_a     = FWD_RF;
        w_fwd_b     = FWD_RF;

        w_ldr_stall = hu.MemtoRegE & ((hu.RA1D == hu.WA3E) | (hu.RA2D == hu.WA3E));

        // R15 is the PC and is never a forwarding source.
        w_match_1m = (r_ra1e == hu.WA3M) & hu.RegWriteM & (hu.WA3M != PC_REG);
        w_match_1w = (r_ra1e == hu.WA3W) & hu.RegWriteW & (hu.WA3W != PC_REG);
        w_match_2m = (r_ra2e == hu.WA3M) & hu.RegWriteM & (hu.WA3M != PC_REG);
        w_match_2w = (r_ra2e == hu.WA3W) & hu.RegWriteW & (hu.WA3W != PC_REG);

        if (reset) begin
            w_fwd_a = fwd_select(w_match_1m, w_match_1w);
            w_fwd_b = fwd_select(w_match_2m, w_match_2w);
        end
    end

    // Every control output is held low while reset is asserted.
    assign w_stall_f = reset & (w_ldr_stall | hu.PCWrPendingF);
    assign w_stall_d = reset & w_ldr_stall;
    assign w_flush_d = reset & (hu.PCWrPendingF | hu.PCSrcW | hu.BranchTakenE);
    assign w_flush_e = reset & (w_ldr_stall | hu.BranchTakenE);

    // Decode-to-Execute copy of source addresses; flush beats the stall hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ra1e <= 4'd0;
            r_ra2e <= 4'd0;
        end else if (w_flush_e) begin
            r_ra1e <= 4'd0;
            r_ra2e <= 4'd0;
        end else if (!w_stall_d) begin
            r_ra1e <= hu.RA1D;
            r_ra2e <= hu.RA2D;
        end
    end

    // Watchdog: HazErr latches on the edge where the stall run reaches MAX_STALL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_run <= 8'd0;
            r_haz_err   <= 1'b0;
        end else if (w_stall_f) begin
            if (r_stall_run != 8'hFF) begin
                r_stall_run <= r_stall_run + 8'd1;
            end
            if (r_stall_run >= STALL_LAST) begin
                r_haz_err <= 1'b1;
            end
        end else begin
            r_stall_run <= 8'd0;
        end
    end

    hazard_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_en    (w_stall_f),
        .o_count (hu.StallCount)
    );

    hazard_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_en    (w_flush_e),
        .o_count (hu.FlushCount)
    );

    assign hu.ForwardAE = w_fwd_a;
    assign hu.ForwardBE = w_fwd_b;
    assign hu.StallF    = w_stall_f;
    assign hu.StallD    = w_stall_d;
    assign hu.FlushD    = w_flush_d;
    assign hu.FlushE    = w_flush_e;
    assign hu.HazErr    = r_haz_err;

endmodule
